// File: rtl/path_trace_pkg.sv
// Shared types and constants for the path_cost/path_dir grid walkers.
// Direction codes are {valid, k} with k = N, NE, E, SE, S, SW, W, NW.
package dkstr_pkg;

    localparam int COST_W = 12;
    localparam int DIR_W  = 4;

    localparam logic [COST_W-1:0] COST_INF = 12'hFFF;

    localparam logic [DIR_W-1:0] DIR_NONE = 4'b0000;
    localparam logic [DIR_W-1:0] DIR_N    = 4'b1000;
    localparam logic [DIR_W-1:0] DIR_NE   = 4'b1001;
    localparam logic [DIR_W-1:0] DIR_E    = 4'b1010;
    localparam logic [DIR_W-1:0] DIR_SE   = 4'b1011;
    localparam logic [DIR_W-1:0] DIR_S    = 4'b1100;
    localparam logic [DIR_W-1:0] DIR_SW   = 4'b1101;
    localparam logic [DIR_W-1:0] DIR_W_   = 4'b1110;
    localparam logic [DIR_W-1:0] DIR_NW   = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WT,
        EMIT,
        FIN
    } state_t;

endpackage

// File: rtl/path_trace_if.sv
// Grid read port plus coordinate output stream of the path tracer.
// PATH_TRACE_COST_EN adds out_cost to the stream.
interface path_trace_if
    import dkstr_pkg::*;
#(
    parameter int CW = 5
) ();

    logic              rd_en;
    logic [CW-1:0]     rd_x;
    logic [CW-1:0]     rd_y;
    logic [COST_W-1:0] rd_cost;
    logic [DIR_W-1:0]  rd_dir;

    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_x;
    logic [CW-1:0]     out_y;
    logic              out_last;
`ifdef PATH_TRACE_COST_EN
    logic [COST_W-1:0] out_cost;
`endif

    modport master (
        output rd_en, rd_x, rd_y,
        input  rd_cost, rd_dir,
        output out_valid, out_x, out_y, out_last,
`ifdef PATH_TRACE_COST_EN
        output out_cost,
`endif
        input  out_ready
    );

    modport slave (
        input  rd_en, rd_x, rd_y,
        output rd_cost, rd_dir,
        input  out_valid, out_x, out_y, out_last,
`ifdef PATH_TRACE_COST_EN
        input  out_cost,
`endif
        output out_ready
    );

endinterface

// File: rtl/path_trace_dir_step.sv
// Combinational neighbour step: applies a direction code to (x, y) and
// flags results that leave the GRID_W x GRID_H grid (no wraparound).
module dir_step
    import dkstr_pkg::*;
#(
    parameter int GRID_W = 32,
    parameter int GRID_H = 32,
    parameter int CW     = 5
) (
    input  logic [CW-1:0]    x,
    input  logic [CW-1:0]    y,
    input  logic [DIR_W-1:0] dir,
    output logic [CW-1:0]    nx,
    output logic [CW-1:0]    ny,
    output logic             oob
);

    localparam logic signed [CW:0] P1 = {{CW{1'b0}}, 1'b1};
    localparam logic signed [CW:0] M1 = {(CW+1){1'b1}};

    logic signed [CW:0] dx;
    logic signed [CW:0] dy;
    logic signed [CW:0] sx;
    logic signed [CW:0] sy;

    always_comb begin
        dx = '0;
        dy = '0;
        if (dir[3]) begin
            unique case (dir[2:0])
                3'd0: dy = M1;
                3'd1: begin dx = P1; dy = M1; end
                3'd2: dx = P1;
                3'd3: begin dx = P1; dy = P1; end
                3'd4: dy = P1;
                3'd5: begin dx = M1; dy = P1; end
                3'd6: dx = M1;
                default: begin dx = M1; dy = M1; end
            endcase
        end
    end

    // x+1 at the top coordinate overflows to negative, which still reads as out of bounds
    assign sx  = $signed({1'b0, x}) + dx;
    assign sy  = $signed({1'b0, y}) + dy;
    assign nx  = sx[CW-1:0];
    assign ny  = sy[CW-1:0];
    assign oob = dir[3] && ((sx < 0) || (int'(sx) >= GRID_W) ||
                            (sy < 0) || (int'(sy) >= GRID_H));

endmodule

// File: rtl/path_trace.sv
// Walks the path_dir grid from a destination back to its source, streaming
// each visited coordinate. PATH_TRACE_COST_EN adds out_cost and a cost-monotonicity check.
//
// state | meaning
// IDLE  | waiting for start; err holds last result
// RD    | rd_en for the current node
// WT    | grid data returns; classify node
// EMIT  | present coordinate until accepted
// FIN   | one-cycle done pulse
module path_trace
    import dkstr_pkg::*;
#(
    parameter int GRID_W    = 32,
    parameter int GRID_H    = 32,
    parameter int CW        = 5,
    parameter int MAX_STEPS = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] start_x,
    input  logic [CW-1:0] start_y,
    path_trace_if.master  bus,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int SW = $clog2(MAX_STEPS + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cur_x_q, cur_x_d;
    logic [CW-1:0] cur_y_q, cur_y_d;
    logic [CW-1:0] nxt_x_q, nxt_x_d;
    logic [CW-1:0] nxt_y_q, nxt_y_d;
    logic          last_q, last_d;
    logic          oob_q, oob_d;
    logic          err_q, err_d;
    logic [SW-1:0] step_q, step_d;
`ifdef PATH_TRACE_COST_EN
    logic [COST_W-1:0] cost_q, cost_d;
`endif

    logic [CW-1:0] step_x;
    logic [CW-1:0] step_y;
    logic          step_oob;
    logic          start_oob;

    dir_step #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .CW     (CW)
    ) u_dir_step (
        .x   (cur_x_q),
        .y   (cur_y_q),
        .dir (bus.rd_dir),
        .nx  (step_x),
        .ny  (step_y),
        .oob (step_oob)
    );

    assign start_oob = (32'(start_x) >= GRID_W) || (32'(start_y) >= GRID_H);

    always_comb begin
        state_d = state_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        nxt_x_d = nxt_x_q;
        nxt_y_d = nxt_y_q;
        last_d  = last_q;
        oob_d   = oob_q;
        err_d   = err_q;
        step_d  = step_q;
`ifdef PATH_TRACE_COST_EN
        cost_d  = cost_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_x_d = start_x;
                    cur_y_d = start_y;
                    err_d   = 1'b0;
                    step_d  = '0;
                    last_d  = 1'b0;
                    oob_d   = 1'b0;
                    if (start_oob) err_d = 1'b1;
                    else           state_d = RD;
                end
            end
            RD: state_d = WT;
            WT: begin
                state_d = IDLE;
                if (bus.rd_cost == COST_INF) begin
                    err_d = 1'b1;
`ifdef PATH_TRACE_COST_EN
                end else if ((step_q != '0) && (bus.rd_cost >= cost_q)) begin
                    err_d = 1'b1;
`endif
                end else if (bus.rd_dir == DIR_NONE) begin
                    if (bus.rd_cost == '0) begin
                        last_d  = 1'b1;
                        state_d = EMIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (!bus.rd_dir[3]) begin
                    err_d = 1'b1;
                end else begin
                    // A node pointing off-grid is still reported; the error fires once it is accepted
                    nxt_x_d = step_x;
                    nxt_y_d = step_y;
                    oob_d   = step_oob;
                    last_d  = 1'b0;
                    state_d = EMIT;
                end
`ifdef PATH_TRACE_COST_EN
                if (state_d == EMIT) cost_d = bus.rd_cost;
`endif
            end
            EMIT: begin
                if (bus.out_ready) begin
                    step_d = step_q + SW'(1);
                    if (last_q) begin
                        state_d = FIN;
                    end else if (oob_q || (step_d == SW'(MAX_STEPS))) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cur_x_d = nxt_x_q;
                        cur_y_d = nxt_y_q;
                        state_d = RD;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_x_q <= '0;
            cur_y_q <= '0;
            nxt_x_q <= '0;
            nxt_y_q <= '0;
            last_q  <= 1'b0;
            oob_q   <= 1'b0;
            err_q   <= 1'b0;
            step_q  <= '0;
`ifdef PATH_TRACE_COST_EN
            cost_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            nxt_x_q <= nxt_x_d;
            nxt_y_q <= nxt_y_d;
            last_q  <= last_d;
            oob_q   <= oob_d;
            err_q   <= err_d;
            step_q  <= step_d;
`ifdef PATH_TRACE_COST_EN
            cost_q  <= cost_d;
`endif
        end
    end

    assign bus.rd_en     = (state_q == RD);
    assign bus.rd_x      = cur_x_q;
    assign bus.rd_y      = cur_y_q;
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_x     = cur_x_q;
    assign bus.out_y     = cur_y_q;
    assign bus.out_last  = (state_q == EMIT) && last_q;
`ifdef PATH_TRACE_COST_EN
    assign bus.out_cost  = cost_q;
`endif

    assign busy = (state_q == RD) || (state_q == WT) || (state_q == EMIT);
    assign done = (state_q == FIN);
    assign err  = err_q;

endmodule

// File: tb/tb_path_trace.sv
// Directed bench for path_trace: a grid memory model answers reads, expected
// beats are queued per test and a monitor pops and compares accepted beats.
module tb_path_trace;

    localparam int CW = 6;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] start_x = '0;
    logic [CW-1:0] start_y = '0;
    logic          busy, done, err;

    path_trace_if #(.CW(CW)) pt_if ();

    path_trace #(
        .GRID_W    (32),
        .GRID_H    (32),
        .CW        (CW),
        .MAX_STEPS (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .start_x (start_x),
        .start_y (start_y),
        .bus     (pt_if.master),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    logic [11:0] cost_mem [0:63][0:63];
    logic [3:0]  dir_mem  [0:63][0:63];

    always @(posedge clk) begin
        if (pt_if.rd_en) begin
            pt_if.rd_cost <= cost_mem[pt_if.rd_y][pt_if.rd_x];
            pt_if.rd_dir  <= dir_mem[pt_if.rd_y][pt_if.rd_x];
        end
    end

    int    n_cmp = 0;
    int    n_bad = 0;
    int    done_cnt = 0;
    int    rd_cnt = 0;
    beat_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Backpressure: when enabled, hold out_ready low for several cycles per beat
    logic bp_en = 1'b0;
    int   hold = 0;
    initial pt_if.out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (!bp_en) begin
            pt_if.out_ready = 1'b1;
        end else if (pt_if.out_valid && !pt_if.out_ready) begin
            if (hold == 4) pt_if.out_ready = 1'b1;
            else           hold++;
        end else begin
            pt_if.out_ready = 1'b0;
            hold = 0;
        end
    end

    logic          stall_pend = 1'b0;
    logic [CW-1:0] stall_x, stall_y;
    logic          stall_l;
    beat_t         got;

    always @(negedge clk) begin
        if (done)        done_cnt++;
        if (pt_if.rd_en) rd_cnt++;
        if (pt_if.out_valid) begin
            if (stall_pend) begin
                chk("hold_x", 32'(pt_if.out_x), 32'(stall_x));
                chk("hold_y", 32'(pt_if.out_y), 32'(stall_y));
                chk("hold_last", 32'(pt_if.out_last), 32'(stall_l));
            end
            if (pt_if.out_ready) begin
                stall_pend = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(pt_if.out_x), 32'hFFFF_FFFF);
                end else begin
                    got = exp_q.pop_front();
                    chk("beat_x", 32'(pt_if.out_x), 32'(got.x));
                    chk("beat_y", 32'(pt_if.out_y), 32'(got.y));
                    chk("beat_last", 32'(pt_if.out_last), 32'(got.last));
                end
            end else begin
                stall_pend = 1'b1;
                stall_x    = pt_if.out_x;
                stall_y    = pt_if.out_y;
                stall_l    = pt_if.out_last;
            end
        end else begin
            stall_pend = 1'b0;
        end
    end

    task automatic clear_grid();
        for (int yy = 0; yy < 64; yy++)
            for (int xx = 0; xx < 64; xx++) begin
                cost_mem[yy][xx] = 12'hFFF;
                dir_mem[yy][xx]  = 4'b0000;
            end
    endtask

    task automatic set_node(input int x, input int y, input logic [11:0] c, input logic [3:0] d);
        cost_mem[y][x] = c;
        dir_mem[y][x]  = d;
    endtask

    task automatic push(input int x, input int y, input logic l);
        beat_t b;
        b.x = CW'(x);
        b.y = CW'(y);
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic do_start(input int x, input int y);
        @(posedge clk);
        #1;
        start   = 1'b1;
        start_x = CW'(x);
        start_y = CW'(y);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk(name, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic straight_grid();
        clear_grid();
        set_node(0, 0, 12'd0, 4'b0000);
        set_node(1, 0, 12'd2, 4'b1110);
        set_node(2, 0, 12'd4, 4'b1110);
        set_node(3, 0, 12'd6, 4'b1110);
    endtask

    int d0, r0, n;

    initial begin
        pt_if.rd_cost = '0;
        pt_if.rd_dir  = '0;
        clear_grid();
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(pt_if.out_valid), 0);
        chk("rst_rd_en", 32'(pt_if.rd_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_out_x", 32'(pt_if.out_x), 0);
        rst_n = 1'b1;

        // straight path along row 0
        straight_grid();
        push(3, 0, 0); push(2, 0, 0); push(1, 0, 0); push(0, 0, 1);
        d0 = done_cnt;
        do_start(3, 0);
        chk("straight_busy", 32'(busy), 1);
        wait_idle("straight_timeout");
        chk("straight_left", 32'(exp_q.size()), 0);
        chk("straight_done", 32'(done_cnt - d0), 1);
        chk("straight_err", 32'(err), 0);

        // diagonal with backpressure
        clear_grid();
        set_node(2, 2, 12'd6, 4'b1111);
        set_node(1, 1, 12'd3, 4'b1111);
        set_node(0, 0, 12'd0, 4'b0000);
        push(2, 2, 0); push(1, 1, 0); push(0, 0, 1);
        bp_en = 1'b1;
        d0 = done_cnt;
        do_start(2, 2);
        wait_idle("diag_timeout");
        bp_en = 1'b0;
        chk("diag_left", 32'(exp_q.size()), 0);
        chk("diag_done", 32'(done_cnt - d0), 1);
        chk("diag_err", 32'(err), 0);

        // unreachable destination
        clear_grid();
        d0 = done_cnt;
        do_start(7, 7);
        wait_idle("unreach_timeout");
        chk("unreach_err", 32'(err), 1);
        chk("unreach_busy", 32'(busy), 0);
        chk("unreach_done", 32'(done_cnt - d0), 0);

        // west edge: node points off-grid
        clear_grid();
        set_node(0, 5, 12'd5, 4'b1110);
        push(0, 5, 0);
        d0 = done_cnt;
        do_start(0, 5);
        wait_idle("oob_timeout");
        chk("oob_left", 32'(exp_q.size()), 0);
        chk("oob_err", 32'(err), 1);
        chk("oob_done", 32'(done_cnt - d0), 0);

        // straight path again to clear err, then a bad start coordinate
        straight_grid();
        push(3, 0, 0); push(2, 0, 0); push(1, 0, 0); push(0, 0, 1);
        do_start(3, 0);
        wait_idle("clear_timeout");
        chk("clear_err", 32'(err), 0);
        r0 = rd_cnt;
        do_start(40, 0);
        repeat (3) @(negedge clk);
        chk("badstart_err", 32'(err), 1);
        chk("badstart_busy", 32'(busy), 0);
        chk("badstart_rd", 32'(rd_cnt - r0), 0);

        // two-node loop hits the step limit
        clear_grid();
        set_node(4, 4, 12'd3, 4'b1010);
        set_node(5, 4, 12'd3, 4'b1110);
        for (int i = 0; i < 8; i++) push((i % 2 == 0) ? 4 : 5, 4, 0);
        d0 = done_cnt;
        do_start(4, 4);
        wait_idle("loop_timeout");
        chk("loop_left", 32'(exp_q.size()), 0);
        chk("loop_err", 32'(err), 1);
        chk("loop_done", 32'(done_cnt - d0), 0);

        // reset while a beat is pending
        straight_grid();
        push(3, 0, 0);
        bp_en = 1'b1;
        do_start(3, 0);
        n = 0;
        while (!pt_if.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wait_valid", 32'(pt_if.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(pt_if.out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_err", 32'(err), 0);
        chk("midrst_out_x", 32'(pt_if.out_x), 0);
        chk("midrst_rd_x", 32'(pt_if.rd_x), 0);
        exp_q.delete();
        bp_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push(3, 0, 0); push(2, 0, 0); push(1, 0, 0); push(0, 0, 1);
        d0 = done_cnt;
        do_start(3, 0);
        wait_idle("after_rst_timeout");
        chk("after_rst_left", 32'(exp_q.size()), 0);
        chk("after_rst_done", 32'(done_cnt - d0), 1);
        chk("after_rst_err", 32'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
